// File: rtl/sr_rx_pkg.sv
// Shared definitions for the shift-register link receiver: FSM encoding and default frame sizes.
package sr_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DYN  = 2'b01,
        STAT = 2'b10
    } rx_state_e;

    localparam int SIZESRDYN_DEF  = 16;
    localparam int SIZESRSTAT_DEF = 88;
    localparam int GAP_MAX_DEF    = 64;

endpackage

// File: rtl/sr_sync2.sv
// Two-flop synchronizer for one link line, with an optional falling-edge pulse
// derived from the synchronized level.
module sr_sync2 #(
    parameter bit EDGE_EN = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q,
    output logic fall
);

    logic [1:0] sync_r;

    // Metastability chain into the CLK domain
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], d};
        end
    end

    assign q = sync_r[1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_r;

            // Previous synchronized level for edge detection
            always_ff @(posedge CLK) begin
                if (RST) begin
                    prev_r <= 1'b0;
                end else begin
                    prev_r <= sync_r[1];
                end
            end

            assign fall = prev_r & ~sync_r[1];
        end else begin : g_no_edge
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/sr_frame_rx.sv
// Receive-side deserializer for the dynamic/static shift-register link, oversampled in the CLK domain.
// Optional inter-bit gap timeout is enabled by defining SR_RX_TIMEOUT_EN.
module sr_frame_rx
    import sr_rx_pkg::*;
#(
    parameter int SIZESRDYN  = SIZESRDYN_DEF,
    parameter int SIZESRSTAT = SIZESRSTAT_DEF
`ifdef SR_RX_TIMEOUT_EN
    ,
    parameter int GAP_MAX    = GAP_MAX_DEF
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CLK_UC,
    input  logic                  SEL,
    input  logic                  MOSI,
    output logic [SIZESRDYN-1:0]  DYN_DATA,
    output logic                  DYN_VALID,
    output logic [SIZESRSTAT-1:0] STAT_DATA,
    output logic                  STAT_VALID,
    output logic                  FRAME_ERR,
    output logic                  BUSY
);

    localparam int CW = $clog2(SIZESRSTAT + 1);

    logic                  uc_fall_s;
    logic                  uc_lvl_s;
    logic                  sel_s;
    logic                  sel_fall_s;
    logic                  mosi_s;
    logic                  mosi_fall_s;
    logic                  timeout_s;
    rx_state_e             state_r;
    logic [CW-1:0]         cnt_r;
    logic [SIZESRDYN-1:0]  dyn_sh_r;
    logic [SIZESRSTAT-1:0] stat_sh_r;

    sr_sync2 #(.EDGE_EN(1'b1)) u_sync_uc   (.CLK(CLK), .RST(RST), .d(CLK_UC), .q(uc_lvl_s), .fall(uc_fall_s));
    sr_sync2 #(.EDGE_EN(1'b0)) u_sync_sel  (.CLK(CLK), .RST(RST), .d(SEL),    .q(sel_s),    .fall(sel_fall_s));
    sr_sync2 #(.EDGE_EN(1'b0)) u_sync_mosi (.CLK(CLK), .RST(RST), .d(MOSI),   .q(mosi_s),   .fall(mosi_fall_s));

`ifdef SR_RX_TIMEOUT_EN
    localparam int GW = $clog2(GAP_MAX + 1);
    logic [GW-1:0] gap_r;

    assign timeout_s = (gap_r == GW'(GAP_MAX - 1)) && !uc_fall_s;

    // Cycles since the last sample while a frame is open
    always_ff @(posedge CLK) begin
        if (RST) begin
            gap_r <= '0;
        end else if (uc_fall_s || timeout_s || ((state_r != DYN) && (state_r != STAT))) begin
            gap_r <= '0;
        end else begin
            gap_r <= gap_r + GW'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Frame FSM: shift registers, counter and all registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            dyn_sh_r   <= '0;
            stat_sh_r  <= '0;
            DYN_DATA   <= '0;
            STAT_DATA  <= '0;
            DYN_VALID  <= 1'b0;
            STAT_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            DYN_VALID  <= 1'b0;
            STAT_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            case (state_r)
                IDLE: begin
                    // The first dynamic bit both opens the frame and counts as bit 1
                    if (uc_fall_s && !sel_s) begin
                        dyn_sh_r <= {dyn_sh_r[SIZESRDYN-2:0], mosi_s};
                        cnt_r    <= CW'(1);
                        state_r  <= DYN;
                        BUSY     <= 1'b1;
                    end else begin
                        BUSY     <= 1'b0;
                    end
                end
                DYN: begin
                    if (uc_fall_s && !sel_s) begin
                        dyn_sh_r <= {dyn_sh_r[SIZESRDYN-2:0], mosi_s};
                        if (cnt_r == CW'(SIZESRDYN - 1)) begin
                            DYN_DATA  <= {dyn_sh_r[SIZESRDYN-2:0], mosi_s};
                            DYN_VALID <= 1'b1;
                            cnt_r     <= '0;
                            state_r   <= STAT;
                        end else begin
                            cnt_r     <= cnt_r + CW'(1);
                        end
                    end else if (uc_fall_s || timeout_s) begin
                        FRAME_ERR <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                        BUSY      <= 1'b0;
                    end else begin
                        BUSY      <= 1'b1;
                    end
                end
                STAT: begin
                    if (uc_fall_s && sel_s) begin
                        stat_sh_r <= {stat_sh_r[SIZESRSTAT-2:0], mosi_s};
                        if (cnt_r == CW'(SIZESRSTAT - 1)) begin
                            STAT_DATA  <= {stat_sh_r[SIZESRSTAT-2:0], mosi_s};
                            STAT_VALID <= 1'b1;
                            cnt_r      <= '0;
                            state_r    <= IDLE;
                            BUSY       <= 1'b0;
                        end else begin
                            cnt_r      <= cnt_r + CW'(1);
                        end
                    end else if (uc_fall_s || timeout_s) begin
                        FRAME_ERR <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= IDLE;
                        BUSY      <= 1'b0;
                    end else begin
                        BUSY      <= 1'b1;
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_frame_rx.sv
// Self-checking bench for sr_frame_rx: frame-level reference model compared every cycle,
// plus literal checks of the directed scenarios.
module tb_sr_frame_rx;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CLK_UC;
    logic        SEL;
    logic        MOSI;
    logic [15:0] DYN_DATA;
    logic        DYN_VALID;
    logic [87:0] STAT_DATA;
    logic        STAT_VALID;
    logic        FRAME_ERR;
    logic        BUSY;

    localparam logic [15:0] T1D = 16'hABCD;
    localparam logic [87:0] T1S = 88'h123456789ABCDEF1234567;

    sr_frame_rx dut (
        .CLK(CLK), .RST(RST), .CLK_UC(CLK_UC), .SEL(SEL), .MOSI(MOSI),
        .DYN_DATA(DYN_DATA), .DYN_VALID(DYN_VALID),
        .STAT_DATA(STAT_DATA), .STAT_VALID(STAT_VALID),
        .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          kind;   // 0 busy change, 1 dyn word, 2 stat word, 3 error
        logic [87:0] data;
        logic        busy;
    } ev_t;
    ev_t evq[$];

    // frame-level model state
    int          m_mode = 0;   // 0 waiting, 1 collecting dynamic, 2 collecting static
    int          m_n = 0;
    logic [87:0] m_acc = '0;
    int          last_due = 0;

    logic [15:0] e_dyn = '0;
    logic [87:0] e_stat = '0;
    logic        e_busy = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int n_dyn = 0, n_stat = 0, n_err = 0;
    bit chk_en = 1'b0;

    function automatic void push_at(input int due, input int kind, input logic [87:0] d, input logic b);
        ev_t e;
        e.due = due; e.kind = kind; e.data = d; e.busy = b;
        evq.push_back(e);
    endfunction

    // A pin falling edge driven now becomes visible three CLK edges later.
    function automatic void model_fall(input logic s, input logic d);
        int due;
        due = cyc + 3;
        last_due = due;
        if (m_mode == 0) begin
            if (!s) begin
                m_acc = {87'd0, d}; m_n = 1; m_mode = 1;
                push_at(due, 0, 88'd0, 1'b1);
            end
        end else if (m_mode == 1) begin
            if (!s) begin
                m_acc = {m_acc[86:0], d}; m_n = m_n + 1;
                if (m_n == 16) begin
                    push_at(due, 1, m_acc, 1'b1);
                    m_mode = 2; m_n = 0; m_acc = '0;
                end
            end else begin
                push_at(due, 3, 88'd0, 1'b0);
                m_mode = 0; m_n = 0;
            end
        end else begin
            if (s) begin
                m_acc = {m_acc[86:0], d}; m_n = m_n + 1;
                if (m_n == 88) begin
                    push_at(due, 2, m_acc, 1'b0);
                    m_mode = 0; m_n = 0;
                end
            end else begin
                push_at(due, 3, 88'd0, 1'b0);
                m_mode = 0; m_n = 0;
            end
        end
    endfunction

    // per-cycle comparison against the model, away from the rising edge
    always @(negedge CLK) begin
        logic e_dv, e_sv, e_err;
        #2;
        if (chk_en) begin
            e_dv = 1'b0; e_sv = 1'b0; e_err = 1'b0;
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                ev_t e;
                e = evq.pop_front();
                e_busy = e.busy;
                if (e.kind == 1) begin e_dv = 1'b1; e_dyn = e.data[15:0]; end
                if (e.kind == 2) begin e_sv = 1'b1; e_stat = e.data; end
                if (e.kind == 3) e_err = 1'b1;
            end
            vectors = vectors + 1;
            if (DYN_VALID !== e_dv)   begin miscompares++; $display("FAIL dyn_valid cyc %0d: got %b expected %b", cyc, DYN_VALID, e_dv); end
            if (STAT_VALID !== e_sv)  begin miscompares++; $display("FAIL stat_valid cyc %0d: got %b expected %b", cyc, STAT_VALID, e_sv); end
            if (FRAME_ERR !== e_err)  begin miscompares++; $display("FAIL frame_err cyc %0d: got %b expected %b", cyc, FRAME_ERR, e_err); end
            if (BUSY !== e_busy)      begin miscompares++; $display("FAIL busy cyc %0d: got %b expected %b", cyc, BUSY, e_busy); end
            if (DYN_DATA !== e_dyn)   begin miscompares++; $display("FAIL dyn_data cyc %0d: got %h expected %h", cyc, DYN_DATA, e_dyn); end
            if (STAT_DATA !== e_stat) begin miscompares++; $display("FAIL stat_data cyc %0d: got %h expected %h", cyc, STAT_DATA, e_stat); end
            if (DYN_VALID === 1'b1)  n_dyn++;
            if (STAT_VALID === 1'b1) n_stat++;
            if (FRAME_ERR === 1'b1)  n_err++;
        end
    end

    task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic s, input logic d);
        SEL = s; MOSI = d; CLK_UC = 1'b1;
        idle(3);
        CLK_UC = 1'b0;
        model_fall(s, d);
        idle(3);
    endtask

    task automatic send_dyn(input logic [15:0] w, input int hi, input int n);
        for (int i = hi; i > hi - n; i--) send_bit(1'b0, w[i]);
    endtask

    task automatic send_stat(input logic [87:0] w, input int n);
        for (int i = 87; i > 87 - n; i--) send_bit(1'b1, w[i]);
    endtask

    task automatic stall(input int n);
`ifdef SR_RX_TIMEOUT_EN
        if (m_mode != 0) begin
            push_at(last_due + 64, 3, 88'd0, 1'b0);
            m_mode = 0; m_n = 0;
        end
`endif
        idle(n);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        evq.delete();
        e_dyn = '0; e_stat = '0; e_busy = 1'b0;
        m_mode = 0; m_n = 0; m_acc = '0;
    endtask

    initial begin
        int d0, s0, r0;
        RST = 1'b1; CLK_UC = 1'b0; SEL = 1'b1; MOSI = 1'b0;
        idle(3);
        chk_en = 1'b1;
        idle(1);
        RST = 1'b0;
        idle(1);
        chk("reset_dyn_data", {72'd0, DYN_DATA}, 88'd0);
        chk("reset_stat_data", STAT_DATA, 88'd0);
        chk("reset_busy", {87'd0, BUSY}, 88'd0);

        // T1 nominal frame
        send_dyn(T1D, 15, 16);
        send_stat(T1S, 88);
        idle(2);
        chk("t1_dyn_data", {72'd0, DYN_DATA}, {72'd0, 16'hABCD});
        chk("t1_stat_data", STAT_DATA, 88'h123456789ABCDEF1234567);
        chk("t1_dyn_strobes", 88'(n_dyn), 88'd1);
        chk("t1_stat_strobes", 88'(n_stat), 88'd1);
        chk("t1_err_strobes", 88'(n_err), 88'd0);

        // T2 SEL rises after 10 dynamic bits
        send_dyn(16'h1F2E, 15, 10);
        send_bit(1'b1, 1'b1);
        idle(2);
        chk("t2_err_strobes", 88'(n_err), 88'd1);
        chk("t2_dyn_kept", {72'd0, DYN_DATA}, {72'd0, 16'hABCD});
        chk("t2_busy", {87'd0, BUSY}, 88'd0);

        // T3 idle noise with SEL=1
        d0 = n_dyn; s0 = n_stat; r0 = n_err;
        for (int i = 0; i < 20; i++) send_bit(1'b1, i[0]);
        chk("t3_strobes", 88'(n_dyn + n_stat + n_err - d0 - s0 - r0), 88'd0);
        chk("t3_busy", {87'd0, BUSY}, 88'd0);

        // T4 reset after 40 static bits, then a full frame
        send_dyn(16'h5A5A, 15, 16);
        send_stat(T1S, 40);
        do_reset();
        chk("t4_dyn_zero", {72'd0, DYN_DATA}, 88'd0);
        chk("t4_stat_zero", STAT_DATA, 88'd0);
        chk("t4_busy_zero", {87'd0, BUSY}, 88'd0);
        send_dyn(T1D, 15, 16);
        send_stat(T1S, 88);
        idle(2);
        chk("t4_dyn_data", {72'd0, DYN_DATA}, {72'd0, 16'hABCD});
        chk("t4_stat_data", STAT_DATA, 88'h123456789ABCDEF1234567);

        // T5 clock stall after 5 dynamic bits
        r0 = n_err;
        send_dyn(16'hC3E1, 15, 5);
        stall(100);
`ifdef SR_RX_TIMEOUT_EN
        chk("t5_timeout_err", 88'(n_err - r0), 88'd1);
        chk("t5_busy", {87'd0, BUSY}, 88'd0);
`else
        chk("t5_no_err", 88'(n_err - r0), 88'd0);
        chk("t5_busy_wait", {87'd0, BUSY}, 88'd1);
`endif
        send_dyn(16'hC3E1, 10, 11);
        send_stat(T1S, 88);
        idle(2);
`ifndef SR_RX_TIMEOUT_EN
        chk("t5_dyn_data", {72'd0, DYN_DATA}, {72'd0, 16'hC3E1});
`endif

        // T6 two frames back to back
        d0 = n_dyn; s0 = n_stat;
        send_dyn(T1D, 15, 16);
        send_stat(T1S, 88);
        send_dyn(T1D, 15, 16);
        send_stat(T1S, 88);
        idle(2);
        chk("t6_dyn_strobes", 88'(n_dyn - d0), 88'd2);
        chk("t6_stat_strobes", 88'(n_stat - s0), 88'd2);
        chk("t6_dyn_data", {72'd0, DYN_DATA}, {72'd0, 16'hABCD});
        chk("t6_stat_data", STAT_DATA, 88'h123456789ABCDEF1234567);

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
